// File: rtl/instruction_loader_if.sv
// Byte-stream and instruction-RAM write bus between the program source and the loader.
// master = stimulus/host side, slave = instruction_loader.
interface instruction_loader_if;
  logic        Start;
  logic [8:0]  WordCount;
  logic [7:0]  RxData;
  logic        RxValid;
  logic        RxReady;
  logic        WrEn;
  logic [31:0] WrAddr;
  logic [31:0] WrData;
  logic        CpuHold;
  logic        Done;
  logic        Error;

  modport master (
    output Start, WordCount, RxData, RxValid,
    input  RxReady, WrEn, WrAddr, WrData, CpuHold, Done, Error
  );

  modport slave (
    input  Start, WordCount, RxData, RxValid,
    output RxReady, WrEn, WrAddr, WrData, CpuHold, Done, Error
  );
endinterface

// File: rtl/instruction_loader.sv
// Assembles big-endian byte stream into 32-bit words and writes them to instruction RAM,
// holding the CPU in reset while loading; aborts on an inter-byte timeout.
module instruction_loader #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic                 clk,
  input  logic                 reset,
  instruction_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t      r_state;
  logic [1:0]  r_byte_cnt;
  logic [7:0]  r_index;
  logic [8:0]  r_count;
  logic [31:0] r_word;
  logic [15:0] r_tmo;

  state_t      w_state_nxt;
  logic [1:0]  w_byte_cnt_nxt;
  logic [7:0]  w_index_nxt;
  logic [8:0]  w_count_nxt;
  logic [31:0] w_word_nxt;
  logic [15:0] w_tmo_nxt;
  logic        w_accept;
  logic        w_last_word;

  // First byte of a word lands in the most significant lane.
  function automatic logic [31:0] f_insert_byte(input logic [31:0] word,
                                                input logic [1:0]  pos,
                                                input logic [7:0]  b);
    logic [31:0] res;
    res = word;
    case (pos)
      2'd0:    res[31:24] = b;
      2'd1:    res[23:16] = b;
      2'd2:    res[15:8]  = b;
      default: res[7:0]   = b;
    endcase
    return res;
  endfunction

  assign w_accept    = bus.RxValid && (r_state == S_RECV);
  assign w_last_word = ({1'b0, r_index} == (r_count - 9'd1));

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_byte_cnt <= 2'd0;
      r_index    <= 8'd0;
      r_count    <= 9'd0;
      r_word     <= 32'd0;
      r_tmo      <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_index    <= w_index_nxt;
      r_count    <= w_count_nxt;
      r_word     <= w_word_nxt;
      r_tmo      <= w_tmo_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_byte_cnt_nxt = r_byte_cnt;
    w_index_nxt    = r_index;
    w_count_nxt    = r_count;
    w_word_nxt     = r_word;
    w_tmo_nxt      = r_tmo;

    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.Start) begin
          w_byte_cnt_nxt = 2'd0;
          w_index_nxt    = 8'd0;
          w_tmo_nxt      = 16'd0;
          w_count_nxt    = bus.WordCount;
          w_state_nxt    = (bus.WordCount == 9'd0) ? S_DONE : S_RECV;
        end
      end

      S_RECV: begin
        if (w_accept) begin
          w_word_nxt     = f_insert_byte(r_word, r_byte_cnt, bus.RxData);
          w_byte_cnt_nxt = r_byte_cnt + 2'd1;
          w_tmo_nxt      = 16'd0;
          if (r_byte_cnt == 2'd3) begin
            w_state_nxt = S_WRITE;
          end
        end else if (r_byte_cnt != 2'd0) begin
          // Only a partially received word can time out; the partial word is dropped.
          if (r_tmo >= (TIMEOUT - 16'd1)) begin
            w_state_nxt = S_ERROR;
          end else begin
            w_tmo_nxt = r_tmo + 16'd1;
          end
        end
      end

      S_WRITE: begin
        if (w_last_word) begin
          w_state_nxt = S_DONE;
        end else begin
          w_index_nxt    = r_index + 8'd1;
          w_byte_cnt_nxt = 2'd0;
          w_tmo_nxt      = 16'd0;
          w_state_nxt    = S_RECV;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs decode directly from registered state so reset reaches them without a clock.
  assign bus.RxReady = (r_state == S_RECV);
  assign bus.WrEn    = (r_state == S_WRITE);
  assign bus.WrAddr  = {22'd0, r_index, 2'b00};
  assign bus.WrData  = r_word;
  assign bus.CpuHold = (r_state == S_RECV) || (r_state == S_WRITE);
  assign bus.Done    = (r_state == S_DONE);
  assign bus.Error   = (r_state == S_ERROR);

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader with a write scoreboard checked on every WrEn.
module tb_instruction_loader;

  logic clk;
  logic reset;

  instruction_loader_if bus ();

  instruction_loader #(.TIMEOUT(16'd16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          wr_cnt   = 0;
  logic [31:0] last_addr = 32'd0;
  logic [63:0] sb[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [8:0] wc);
    bus.Start     = 1'b1;
    bus.WordCount = wc;
    tick();
    bus.Start     = 1'b0;
  endtask

  // Presents a byte and returns just after the edge where it was accepted.
  task automatic send_byte(input logic [7:0] b, output int waits);
    waits       = 0;
    bus.RxData  = b;
    bus.RxValid = 1'b1;
    while (bus.RxReady !== 1'b1 && waits < 50) begin
      tick();
      waits++;
    end
    if (waits >= 50) chk("rx_ready_wait", {63'd0, bus.RxReady}, 64'd1);
    tick();
  endtask

  task automatic push_exp(input logic [7:0] idx, input logic [31:0] data);
    sb.push_back({22'd0, idx, 2'b00, data});
  endtask

  task automatic send_word(input logic [7:0] idx, input logic [31:0] data);
    int w;
    push_exp(idx, data);
    send_byte(data[31:24], w);
    chk("ready_gap", {63'd0, (w <= 1)}, 64'd1);
    send_byte(data[23:16], w);
    send_byte(data[15:8], w);
    send_byte(data[7:0], w);
    chk("wren_latency", {63'd0, bus.WrEn}, 64'd1);
  endtask

  always @(negedge clk) begin
    if (bus.WrEn === 1'b1) begin
      logic [63:0] e;
      wr_cnt++;
      last_addr = bus.WrAddr;
      n_assert++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_wren: observed addr %0h data %0h expected no write", bus.WrAddr, bus.WrData);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_addr", {32'd0, bus.WrAddr}, {32'd0, e[63:32]});
        chk("wr_data", {32'd0, bus.WrData}, {32'd0, e[31:0]});
        chk("rxready_in_write", {63'd0, bus.RxReady}, 64'd0);
        chk("cpuhold_in_write", {63'd0, bus.CpuHold}, 64'd1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed simulation still running expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int w0;
    int w;
    reset         = 1'b1;
    bus.Start     = 1'b0;
    bus.WordCount = 9'd0;
    bus.RxData    = 8'd0;
    bus.RxValid   = 1'b0;
    repeat (2) tick();

    chk("rst_rxready", {63'd0, bus.RxReady}, 64'd0);
    chk("rst_wren",    {63'd0, bus.WrEn},    64'd0);
    chk("rst_wraddr",  {32'd0, bus.WrAddr},  64'd0);
    chk("rst_wrdata",  {32'd0, bus.WrData},  64'd0);
    chk("rst_cpuhold", {63'd0, bus.CpuHold}, 64'd0);
    chk("rst_done",    {63'd0, bus.Done},    64'd0);
    chk("rst_error",   {63'd0, bus.Error},   64'd0);
    reset = 1'b0;
    tick();
    chk("idle_rxready", {63'd0, bus.RxReady}, 64'd0);

    // Zero-length load goes straight to DONE
    do_start(9'd0);
    chk("wc0_done",    {63'd0, bus.Done},    64'd1);
    chk("wc0_cpuhold", {63'd0, bus.CpuHold}, 64'd0);
    chk("wc0_nowrite", wr_cnt, 64'd0);

    // Two-word load, back-to-back bytes
    w0 = wr_cnt;
    do_start(9'd2);
    chk("start_clears_done", {63'd0, bus.Done},    64'd0);
    chk("recv_cpuhold",      {63'd0, bus.CpuHold}, 64'd1);
    chk("recv_rxready",      {63'd0, bus.RxReady}, 64'd1);
    send_word(8'd0, 32'h08000003);
    send_word(8'd1, 32'h08000071);
    bus.RxValid = 1'b0;
    tick();
    chk("two_done",    {63'd0, bus.Done},    64'd1);
    chk("two_cpuhold", {63'd0, bus.CpuHold}, 64'd0);
    chk("two_count",   wr_cnt - w0, 64'd2);
    chk("two_sb",      sb.size(), 64'd0);

    // Timeout on a partial word; none while waiting for a first byte
    do_start(9'd1);
    bus.RxValid = 1'b0;
    repeat (40) tick();
    chk("wait_first_noerr", {63'd0, bus.Error},   64'd0);
    chk("wait_first_ready", {63'd0, bus.RxReady}, 64'd1);
    w0 = wr_cnt;
    send_byte(8'h00, w);
    send_byte(8'h00, w);
    bus.RxValid = 1'b0;
    repeat (15) tick();
    chk("tmo_15_noerr",   {63'd0, bus.Error},   64'd0);
    chk("tmo_15_cpuhold", {63'd0, bus.CpuHold}, 64'd1);
    tick();
    chk("tmo_error",   {63'd0, bus.Error},   64'd1);
    chk("tmo_cpuhold", {63'd0, bus.CpuHold}, 64'd0);
    chk("tmo_rxready", {63'd0, bus.RxReady}, 64'd0);
    chk("tmo_done",    {63'd0, bus.Done},    64'd0);
    chk("tmo_nowrite", wr_cnt - w0, 64'd0);

    // Start from ERROR behaves like IDLE
    do_start(9'd0);
    chk("err_restart_done",  {63'd0, bus.Done},  64'd1);
    chk("err_restart_error", {63'd0, bus.Error}, 64'd0);

    // Asynchronous reset mid-load
    w0 = wr_cnt;
    do_start(9'd2);
    send_word(8'd0, 32'h12345678);
    send_byte(8'hAA, w);
    send_byte(8'hBB, w);
    bus.RxValid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_rxready", {63'd0, bus.RxReady}, 64'd0);
    chk("arst_wren",    {63'd0, bus.WrEn},    64'd0);
    chk("arst_wraddr",  {32'd0, bus.WrAddr},  64'd0);
    chk("arst_wrdata",  {32'd0, bus.WrData},  64'd0);
    chk("arst_cpuhold", {63'd0, bus.CpuHold}, 64'd0);
    chk("arst_done",    {63'd0, bus.Done},    64'd0);
    chk("arst_error",   {63'd0, bus.Error},   64'd0);
    tick();
    #3 reset = 1'b0;
    bus.RxValid = 1'b1;
    bus.RxData  = 8'h5A;
    repeat (10) tick();
    chk("post_rst_rxready", {63'd0, bus.RxReady}, 64'd0);
    chk("post_rst_cpuhold", {63'd0, bus.CpuHold}, 64'd0);
    chk("post_rst_nowrite", wr_cnt - w0, 64'd1);
    bus.RxValid = 1'b0;
    do_start(9'd1);
    send_word(8'd0, 32'h20040003);
    bus.RxValid = 1'b0;
    tick();
    chk("post_rst_done",  {63'd0, bus.Done}, 64'd1);
    chk("post_rst_count", wr_cnt - w0, 64'd2);
    chk("post_rst_sb",    sb.size(), 64'd0);

    // Start ignored in RECV and WRITE; RxValid held high across WRITE
    w0 = wr_cnt;
    do_start(9'd2);
    push_exp(8'd0, 32'hA1B2C3D4);
    push_exp(8'd1, 32'h11223344);
    send_byte(8'hA1, w);
    send_byte(8'hB2, w);
    bus.Start     = 1'b1;
    bus.WordCount = 9'd5;
    send_byte(8'hC3, w);
    bus.Start     = 1'b0;
    send_byte(8'hD4, w);
    chk("hold_wren", {63'd0, bus.WrEn}, 64'd1);
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    chk("hold_back_recv", {63'd0, bus.RxReady}, 64'd1);
    send_byte(8'h11, w);
    send_byte(8'h22, w);
    send_byte(8'h33, w);
    send_byte(8'h44, w);
    bus.RxValid = 1'b0;
    tick();
    chk("hold_done",  {63'd0, bus.Done}, 64'd1);
    chk("hold_count", wr_cnt - w0, 64'd2);
    chk("hold_sb",    sb.size(), 64'd0);

    // Full 256-word load with random data
    w0 = wr_cnt;
    do_start(9'd256);
    for (int i = 0; i < 256; i++) begin
      send_word(i[7:0], $urandom);
    end
    bus.RxValid = 1'b0;
    tick();
    chk("full_done",      {63'd0, bus.Done},    64'd1);
    chk("full_cpuhold",   {63'd0, bus.CpuHold}, 64'd0);
    chk("full_count",     wr_cnt - w0, 64'd256);
    chk("full_last_addr", {32'd0, last_addr}, 64'h3FC);
    chk("full_sb",        sb.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
